// File: rtl/engine_pkg.sv
// Shared constants and types for the digit-serial add/subtract engine.
package engine_pkg;

  // Default operand width and bits handled per clock.
  localparam int DEF_WIDTH = 32;
  localparam int DEF_DIGIT = 8;

  // Two-state sequencer: waiting for work, or walking the digits.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Digit counter width. It must hold the values 0..n so that the
  // post-increment after the last digit never wraps.
  function automatic int cnt_bits(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/addsub_digit.sv
// One DIGIT-wide ripple slice. It reports the carry out of the slice and
// the carry into the slice MSB, which is used for signed-overflow detection.
module addsub_digit #(
  parameter int DIGIT = 8
) (
  input  logic [DIGIT-1:0] i_a,
  input  logic [DIGIT-1:0] i_b,
  input  logic             i_cin,
  output logic [DIGIT-1:0] o_sum,
  output logic             o_cout,
  output logic             o_cmsb
);

  logic [DIGIT:0] w_full;

  // Widened add. The carry into the MSB is recovered from the MSB sum bit,
  // so the same expression works for DIGIT == 1.
  always_comb begin
    w_full = {1'b0, i_a} + {1'b0, i_b} + {{DIGIT{1'b0}}, i_cin};
    o_sum  = w_full[DIGIT-1:0];
    o_cout = w_full[DIGIT];
    o_cmsb = w_full[DIGIT-1] ^ i_a[DIGIT-1] ^ i_b[DIGIT-1];
  end

endmodule

// File: rtl/addsub_seq.sv
// Digit-serial adder/subtractor. It takes WIDTH/DIGIT cycles per operation,
// least-significant digit first. Flags are updated only on the final digit.
module addsub_seq
  import engine_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DIGIT = DEF_DIGIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = cnt_bits(N);

  // Reject a geometry that would leave a partial digit.
  if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_geometry
    $error("addsub_seq: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic             w_accept;
  logic             w_run;
  logic             w_last;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;      // already conditionally inverted at launch
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_q;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;
  logic             r_done;

  logic [31:0]      w_sh;
  logic [DIGIT-1:0] w_a_dig;
  logic [DIGIT-1:0] w_b_dig;
  logic [DIGIT-1:0] w_sum;
  logic             w_cout;
  logic             w_cmsb;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_q_nxt;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state. A start is taken only while idle. This includes the done
  // cycle, so operations can run back to back.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_run       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_run = 1'b1;
        if (w_last) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Select the current digit of each latched operand. Also build the result
  // word with this digit merged in, which the zero flag uses on the last step.
  always_comb begin
    w_sh    = 32'(r_cnt) * 32'(DIGIT);
    w_last  = (r_cnt == CW'(N - 1));
    w_a_dig = DIGIT'(r_a >> w_sh);
    w_b_dig = DIGIT'(r_b >> w_sh);
    w_mask  = WIDTH'({DIGIT{1'b1}}) << w_sh;
    w_q_nxt = (r_q & ~w_mask) | (WIDTH'(w_sum) << w_sh);
  end

  addsub_digit #(
    .DIGIT (DIGIT)
  ) u_digit (
    .i_a    (w_a_dig),
    .i_b    (w_b_dig),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout),
    .o_cmsb (w_cmsb)
  );

  // Datapath. Operands are latched at launch. Each RUN cycle writes one
  // result digit and passes its carry on. The final digit publishes the
  // flags and the done pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_q     <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_accept) begin
        r_a     <= a;
        r_b     <= sub ? ~b : b;
        r_carry <= cin;
        r_cnt   <= '0;
      end else if (w_run) begin
        r_q     <= w_q_nxt;
        r_carry <= w_cout;
        r_cnt   <= r_cnt + CW'(1);
        if (w_last) begin
          r_cout <= w_cout;
          r_ovf  <= w_cmsb ^ w_cout;
          r_zero <= (w_q_nxt == '0);
          r_done <= 1'b1;
        end
      end
    end
  end

  assign busy = (r_state == ST_RUN);
  assign done = r_done;
  assign q    = r_q;
  assign cout = r_cout;
  assign ovf  = r_ovf;
  assign zero = r_zero;

endmodule

// File: tb/tb_addsub_seq.sv
// Directed and random checks of addsub_seq (32/8 and single-digit 32/32).
module tb_addsub_seq;

  logic        clk = 1'b0;
  logic        reset, start, start1, sub, cin;
  logic [31:0] a, b;
  logic        busy, done, cout, ovf, zero;
  logic [31:0] q;
  logic        busy1, done1, cout1, ovf1, zero1;
  logic [31:0] q1;

  int vecs = 0;
  int errs = 0;

  // expected operation in flight and last completed flags
  logic [31:0] ea, eb;
  logic        es, ec;
  logic        pc, po, pz;

  always #5 clk = ~clk;

  addsub_seq #(.WIDTH(32), .DIGIT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .sub(sub), .cin(cin),
    .busy(busy), .done(done), .q(q), .cout(cout), .ovf(ovf), .zero(zero));

  addsub_seq #(.WIDTH(32), .DIGIT(32)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a), .b(b), .sub(sub), .cin(cin),
    .busy(busy1), .done(done1), .q(q1), .cout(cout1), .ovf(ovf1), .zero(zero1));

  // Reference: plain wide arithmetic. Signed overflow happens when both
  // addends share a sign and the result sign differs from it.
  // Packing: {ovf, zero, cout, q[31:0]}.
  function automatic logic [34:0] model(input logic [31:0] x, y, input logic s, c);
    logic [31:0] yy;
    logic [32:0] sum;
    logic        v;
    yy  = s ? ~y : y;
    sum = {1'b0, x} + {1'b0, yy} + {32'd0, c};
    v   = (x[31] == yy[31]) && (sum[31] != x[31]);
    return {v, (sum[31:0] == 32'd0), sum[32], sum[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Present an operation. When sync is 0 the caller is already at a negedge,
  // for example in the done cycle of a previous operation.
  task automatic start_op(input logic [31:0] ta, tbv, input logic ts, tc, input bit sync);
    if (sync) @(negedge clk);
    a = ta; b = tbv; sub = ts; cin = tc; start = 1'b1;
    ea = ta; eb = tbv; es = ts; ec = tc;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("done_low_after_start", 64'(done), 64'd0);
  endtask

  // Wait for done with a bound, wiggling the data inputs along the way.
  // Flags must hold their previous values until done arrives.
  task automatic wait_done(input int e0);
    logic [34:0] m;
    int          e;
    bit          got;
    e = e0; got = 0;
    while (e < 16 && !got) begin
      @(negedge clk);
      e++;
      if (done) got = 1;
      else begin
        check("hold_flags", {61'd0, cout, ovf, zero}, {61'd0, pc, po, pz});
        a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
      end
    end
    check("done_seen", 64'(got), 64'd1);
    check("latency", 64'(e), 64'd4);
    m = model(ea, eb, es, ec);
    check("q", 64'(q), 64'(m[31:0]));
    check("cout", 64'(cout), 64'(m[32]));
    check("zero", 64'(zero), 64'(m[33]));
    check("ovf", 64'(ovf), 64'(m[34]));
    check("busy_at_done", 64'(busy), 64'd0);
    pc = m[32]; pz = m[33]; po = m[34];
  endtask

  task automatic run1(input logic [31:0] ta, tbv, input logic ts, tc);
    logic [34:0] m;
    @(negedge clk);
    a = ta; b = tbv; sub = ts; cin = tc; start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    check("d1_busy", 64'(busy1), 64'd1);
    check("d1_done_early", 64'(done1), 64'd0);
    @(negedge clk);
    m = model(ta, tbv, ts, tc);
    check("d1_done", 64'(done1), 64'd1);
    check("d1_q", 64'(q1), 64'(m[31:0]));
    check("d1_flags", {61'd0, ovf1, zero1, cout1}, {61'd0, m[34:32]});
  endtask

  initial begin
    logic        b2b;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; start1 = 1'b0;
    a = '0; b = '0; sub = 1'b0; cin = 1'b0;
    // start coincident with reset must be ignored
    @(negedge clk); start = 1'b1; start1 = 1'b1;
    repeat (2) @(negedge clk);
    start = 1'b0; start1 = 1'b0;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_q", 64'(q), 64'd0);
    check("rst_flags", {61'd0, cout, ovf, zero}, 64'd1);
    check("rst_d1", {31'd0, q1, busy1}, 64'd0);
    reset = 1'b0;
    pc = 0; po = 0; pz = 1;
    @(negedge clk);
    check("idle_after_rst", 64'(busy), 64'd0);

    // carry ripples through every digit
    start_op(32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1); wait_done(0);
    // 5 - 7
    start_op(32'd5, 32'd7, 1'b1, 1'b1, 1'b1); wait_done(0);
    // positive overflow, then back-to-back negative overflow
    start_op(32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1); wait_done(0);
    start_op(32'h8000_0000, 32'd1, 1'b1, 1'b1, 1'b0); wait_done(0);

    // restart attempts while busy are ignored
    start_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b1);
    start = 1'b1; a = 32'hDEAD_BEEF; b = 32'hCAFE_F00D; sub = 1'b1; cin = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("no_done_mid", 64'(done), 64'd0);
    end
    start = 1'b0;
    wait_done(3);
    @(negedge clk);
    check("single_done", 64'(done), 64'd0);
    check("restart_ignored", 64'(busy), 64'd0);

    // reset mid-operation aborts it
    start_op(32'hAAAA_5555, 32'h0F0F_0F0F, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_q", 64'(q), 64'd0);
    check("abort_flags", {61'd0, cout, ovf, zero}, 64'd1);
    pc = 0; po = 0; pz = 1;
    start_op(32'd100, 32'd58, 1'b1, 1'b1, 1'b0); wait_done(0);

    // random operations, sometimes launched in the done cycle
    b2b = 1'b0;
    for (int i = 0; i < 30; i++) begin
      ra = $urandom; rb = $urandom;
      if (i % 7 == 3) rb = ra;
      start_op(ra, rb, 1'($urandom), 1'($urandom), !b2b);
      wait_done(0);
      b2b = 1'($urandom);
    end

    // single-digit instance
    run1(32'd3, 32'd4, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      run1($urandom, $urandom, 1'($urandom), 1'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
